// File: rtl/id_ex_reg.sv
// Decode->Execute pipeline register for the RV32I core: captures decoder controls and operands,
// supports hazard stall (hold) and flush (bubble), and counts inserted bubbles for debug.
module id_ex_reg #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int RSRC_WIDTH  = 2,
  parameter int ALUOP_WIDTH = 3,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_d,
  input  logic                   flush_e,
  input  logic                   valid_d,
  input  logic                   reg_write_d,
  input  logic [RSRC_WIDTH-1:0]  result_src_d,
  input  logic                   mem_write_d,
  input  logic                   alu_src_d,
  input  logic                   branch_d,
  input  logic                   jump_d,
  input  logic [ALUOP_WIDTH-1:0] alu_op_d,
  input  logic [2:0]             funct3_d,
  input  logic [DATA_WIDTH-1:0]  rd1_d,
  input  logic [DATA_WIDTH-1:0]  rd2_d,
  input  logic [DATA_WIDTH-1:0]  imm_ext_d,
  input  logic [DATA_WIDTH-1:0]  pc_d,
  input  logic [DATA_WIDTH-1:0]  pc_plus4_d,
  input  logic [ADDR_WIDTH-1:0]  rs1_d,
  input  logic [ADDR_WIDTH-1:0]  rs2_d,
  input  logic [ADDR_WIDTH-1:0]  rd_d,
  output logic                   valid_e,
  output logic                   reg_write_e,
  output logic [RSRC_WIDTH-1:0]  result_src_e,
  output logic                   mem_write_e,
  output logic                   alu_src_e,
  output logic                   branch_e,
  output logic                   jump_e,
  output logic [ALUOP_WIDTH-1:0] alu_op_e,
  output logic [2:0]             funct3_e,
  output logic [DATA_WIDTH-1:0]  rd1_e,
  output logic [DATA_WIDTH-1:0]  rd2_e,
  output logic [DATA_WIDTH-1:0]  imm_ext_e,
  output logic [DATA_WIDTH-1:0]  pc_e,
  output logic [DATA_WIDTH-1:0]  pc_plus4_e,
  output logic [ADDR_WIDTH-1:0]  rs1_e,
  output logic [ADDR_WIDTH-1:0]  rs2_e,
  output logic [ADDR_WIDTH-1:0]  rd_e,
  output logic [CNT_WIDTH-1:0]   bubble_cnt
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic load_p0;
  logic bubble_p0;

  // Flush wins over stall; a bubble is either a flush or an empty decode slot being loaded.
  assign load_p0   = flush_e | ~stall_d;
  assign bubble_p0 = flush_e | ~valid_d;

  // ---- decode -> execute boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_e      <= 1'b0;
      reg_write_e  <= 1'b0;
      result_src_e <= '0;
      mem_write_e  <= 1'b0;
      alu_src_e    <= 1'b0;
      branch_e     <= 1'b0;
      jump_e       <= 1'b0;
      alu_op_e     <= '0;
      funct3_e     <= '0;
      rd1_e        <= '0;
      rd2_e        <= '0;
      imm_ext_e    <= '0;
      pc_e         <= '0;
      pc_plus4_e   <= '0;
      rs1_e        <= '0;
      rs2_e        <= '0;
      rd_e         <= '0;
      bubble_cnt   <= '0;
    end else if (load_p0) begin
      rd1_e      <= rd1_d;
      rd2_e      <= rd2_d;
      imm_ext_e  <= imm_ext_d;
      pc_e       <= pc_d;
      pc_plus4_e <= pc_plus4_d;
      if (bubble_p0) begin
        // Explicit constants so X on undecoded controls can never leak into EX.
        valid_e      <= 1'b0;
        reg_write_e  <= 1'b0;
        result_src_e <= '0;
        mem_write_e  <= 1'b0;
        alu_src_e    <= 1'b0;
        branch_e     <= 1'b0;
        jump_e       <= 1'b0;
        alu_op_e     <= '0;
        funct3_e     <= '0;
        rs1_e        <= '0;
        rs2_e        <= '0;
        rd_e         <= '0;
        bubble_cnt   <= sat_inc(bubble_cnt);
      end else begin
        valid_e      <= 1'b1;
        reg_write_e  <= reg_write_d;
        result_src_e <= result_src_d;
        mem_write_e  <= mem_write_d;
        alu_src_e    <= alu_src_d;
        branch_e     <= branch_d;
        jump_e       <= jump_d;
        alu_op_e     <= alu_op_d;
        funct3_e     <= funct3_d;
        rs1_e        <= rs1_d;
        rs2_e        <= rs2_d;
        rd_e         <= reg_write_d ? rd_d : '0;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed self-checking bench for id_ex_reg (bubble counter narrowed to 4 bits to reach saturation).
module tb_id_ex_reg;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall_d, flush_e, valid_d;
  logic          reg_write_d, mem_write_d, alu_src_d, branch_d, jump_d;
  logic [1:0]    result_src_d;
  logic [2:0]    alu_op_d, funct3_d;
  logic [DW-1:0] rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d;
  logic [AW-1:0] rs1_d, rs2_d, rd_d;

  logic          valid_e, reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e;
  logic [1:0]    result_src_e;
  logic [2:0]    alu_op_e, funct3_e;
  logic [DW-1:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
  logic [AW-1:0] rs1_e, rs2_e, rd_e;
  logic [CW-1:0] bubble_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_reg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSRC_WIDTH(2), .ALUOP_WIDTH(3),
              .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .stall_d(stall_d), .flush_e(flush_e), .valid_d(valid_d),
    .reg_write_d(reg_write_d), .result_src_d(result_src_d), .mem_write_d(mem_write_d),
    .alu_src_d(alu_src_d), .branch_d(branch_d), .jump_d(jump_d), .alu_op_d(alu_op_d),
    .funct3_d(funct3_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_ext_d(imm_ext_d), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .valid_e(valid_e), .reg_write_e(reg_write_e), .result_src_e(result_src_e),
    .mem_write_e(mem_write_e), .alu_src_e(alu_src_e), .branch_e(branch_e), .jump_e(jump_e),
    .alu_op_e(alu_op_e), .funct3_e(funct3_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .imm_ext_e(imm_ext_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .rs1_e(rs1_e),
    .rs2_e(rs2_e), .rd_e(rd_e), .bubble_cnt(bubble_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rtype(input logic [AW-1:0] rd, input logic [DW-1:0] a);
    stall_d = 0; flush_e = 0; valid_d = 1;
    reg_write_d = 1; result_src_d = 2'b00; mem_write_d = 0; alu_src_d = 0;
    branch_d = 0; jump_d = 0; alu_op_d = 3'b000; funct3_d = 3'b000;
    rd1_d = a; rd2_d = 32'h0000_0003; imm_ext_d = 32'h0; pc_d = 32'h0000_0010;
    pc_plus4_d = 32'h0000_0014; rs1_d = 5'd1; rs2_d = 5'd2; rd_d = rd;
  endtask

  task automatic test_reset();
    rst = 1;
    drive_rtype(5'd7, 32'h0000_0005);
    tick(); tick();
    #2 rst = 0;
    tick();
    if (valid_e !== 1'b1 || rd_e !== 5'd7) begin
      failures++; $display("FAIL reset_preload valid_e=%b rd_e=%0d want 1/7", valid_e, rd_e);
    end
    checks++;
    #2 rst = 1;
    #1;
    if ({valid_e, reg_write_e, mem_write_e, branch_e, jump_e, alu_src_e} !== 6'b0 ||
        result_src_e !== 2'b0 || alu_op_e !== 3'b0 || rd_e !== 5'd0) begin
      failures++; $display("FAIL reset_ctrl valid=%b rw=%b rd=%0d want all 0", valid_e, reg_write_e, rd_e);
    end
    checks++;
    if (rd1_e !== 32'h0 || rd2_e !== 32'h0 || pc_e !== 32'h0 || rs1_e !== 5'd0 ||
        rs2_e !== 5'd0 || bubble_cnt !== 4'd0) begin
      failures++; $display("FAIL reset_data rd1=%h pc=%h cnt=%0d want 0", rd1_e, pc_e, bubble_cnt);
    end
    checks++;
    #3 rst = 0;
  endtask

  task automatic test_load();
    drive_rtype(5'd7, 32'h0000_0005);
    tick();
    if (valid_e !== 1'b1 || reg_write_e !== 1'b1 || rd1_e !== 32'h5 || rd_e !== 5'd7 ||
        alu_op_e !== 3'b000 || rs1_e !== 5'd1 || rs2_e !== 5'd2 || rd2_e !== 32'h3) begin
      failures++; $display("FAIL load valid=%b rw=%b rd1=%h rd=%0d want 1/1/5/7",
                           valid_e, reg_write_e, rd1_e, rd_e);
    end
    checks++;
    if (bubble_cnt !== 4'd0) begin
      failures++; $display("FAIL load_cnt got %0d want 0", bubble_cnt);
    end
    checks++;
  endtask

  task automatic test_stall();
    stall_d = 0; flush_e = 0; valid_d = 1;
    reg_write_d = 0; result_src_d = 2'b00; mem_write_d = 1; alu_src_d = 1;
    branch_d = 0; jump_d = 0; alu_op_d = 3'b000; funct3_d = 3'b010;
    rd1_d = 32'h0000_0100; rd2_d = 32'h0000_ABCD; imm_ext_d = 32'h8;
    pc_d = 32'h20; pc_plus4_d = 32'h24; rs1_d = 5'd2; rs2_d = 5'd3; rd_d = 5'd5;
    tick();
    if (mem_write_e !== 1'b1 || reg_write_e !== 1'b0 || rd_e !== 5'd0 || rd2_e !== 32'hABCD ||
        imm_ext_e !== 32'h8 || funct3_e !== 3'b010) begin
      failures++; $display("FAIL store_load mw=%b rw=%b rd=%0d rd2=%h want 1/0/0/abcd",
                           mem_write_e, reg_write_e, rd_e, rd2_e);
    end
    checks++;
    drive_rtype(5'd9, 32'h0000_0077);
    stall_d = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_write_e !== 1'b1 || reg_write_e !== 1'b0 || rd1_e !== 32'h100 ||
          rd2_e !== 32'hABCD || rd_e !== 5'd0 || bubble_cnt !== 4'd0) begin
        failures++; $display("FAIL stall_hold%0d mw=%b rd1=%h cnt=%0d want 1/100/0",
                             i, mem_write_e, rd1_e, bubble_cnt);
      end
      checks++;
    end
    stall_d = 0;
    tick();
    if (mem_write_e !== 1'b0 || reg_write_e !== 1'b1 || rd_e !== 5'd9 || rd1_e !== 32'h77) begin
      failures++; $display("FAIL stall_release mw=%b rw=%b rd=%0d rd1=%h want 0/1/9/77",
                           mem_write_e, reg_write_e, rd_e, rd1_e);
    end
    checks++;
  endtask

  task automatic test_flush_vs_stall();
    drive_rtype(5'd1, 32'h0);
    jump_d = 1; result_src_d = 2'b10; pc_d = 32'h40; pc_plus4_d = 32'h44;
    tick();
    if (jump_e !== 1'b1 || rd_e !== 5'd1 || result_src_e !== 2'b10 || pc_plus4_e !== 32'h44) begin
      failures++; $display("FAIL jal_load jump=%b rd=%0d rsrc=%b want 1/1/10", jump_e, rd_e, result_src_e);
    end
    checks++;
    stall_d = 1; flush_e = 1;
    tick();
    if (jump_e !== 1'b0 || reg_write_e !== 1'b0 || rd_e !== 5'd0 || valid_e !== 1'b0 ||
        result_src_e !== 2'b00 || rs1_e !== 5'd0) begin
      failures++; $display("FAIL flush_over_stall jump=%b rw=%b rd=%0d valid=%b want 0",
                           jump_e, reg_write_e, rd_e, valid_e);
    end
    checks++;
    if (bubble_cnt !== 4'd1) begin
      failures++; $display("FAIL flush_cnt got %0d want 1", bubble_cnt);
    end
    checks++;
    stall_d = 0; flush_e = 0;
  endtask

  task automatic test_invalid();
    drive_rtype(5'd4, 32'h11);
    valid_d = 0; reg_write_d = 1'bx; branch_d = 1'bx; mem_write_d = 1'bx; jump_d = 1'bx;
    tick();
    if (reg_write_e !== 1'b0 || branch_e !== 1'b0 || mem_write_e !== 1'b0 ||
        jump_e !== 1'b0 || valid_e !== 1'b0 || rd_e !== 5'd0) begin
      failures++; $display("FAIL invalid_ctrl rw=%b br=%b mw=%b j=%b want 0",
                           reg_write_e, branch_e, mem_write_e, jump_e);
    end
    checks++;
    if (bubble_cnt !== 4'd2) begin
      failures++; $display("FAIL invalid_cnt got %0d want 2", bubble_cnt);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    drive_rtype(5'd12, 32'hDEAD_0001);
    tick();
    drive_rtype(5'd13, 32'hDEAD_0002);
    branch_d = 1; reg_write_d = 0; funct3_d = 3'b001;
    if (rd_e !== 5'd12 || rd1_e !== 32'hDEAD_0001 || reg_write_e !== 1'b1) begin
      failures++; $display("FAIL b2b_first rd=%0d rd1=%h want 12/dead0001", rd_e, rd1_e);
    end
    checks++;
    tick();
    if (branch_e !== 1'b1 || reg_write_e !== 1'b0 || rd_e !== 5'd0 ||
        rd1_e !== 32'hDEAD_0002 || funct3_e !== 3'b001 || bubble_cnt !== 4'd2) begin
      failures++; $display("FAIL b2b_second br=%b rw=%b rd=%0d rd1=%h cnt=%0d want 1/0/0/dead0002/2",
                           branch_e, reg_write_e, rd_e, rd1_e, bubble_cnt);
    end
    checks++;
  endtask

  task automatic test_saturation();
    logic [CW-1:0] want;
    #2 rst = 1;
    #3 rst = 0;
    drive_rtype(5'd3, 32'h1);
    flush_e = 1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      want = (i >= 15) ? 4'hF : 4'(i);
      if (bubble_cnt !== want) begin
        failures++; $display("FAIL sat_flush%0d got %0d want %0d", i, bubble_cnt, want);
      end
      checks++;
    end
    flush_e = 0; valid_d = 0;
    tick();
    if (bubble_cnt !== 4'hF || valid_e !== 1'b0) begin
      failures++; $display("FAIL sat_hold cnt=%h valid=%b want f/0", bubble_cnt, valid_e);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_stall();
    test_flush_vs_stall();
    test_invalid();
    test_back_to_back();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
